// File: rtl/link_pkg.sv
// Shared constants and types for the host-link command receiver:
// command bytes, write-target / error encodings and FSM states.
package link_pkg;

  localparam logic [7:0] CMD_REBOOT   = 8'h30;
  localparam logic [7:0] CMD_BREAK    = 8'h31;
  localparam logic [7:0] CMD_START    = 8'h32;
  localparam logic [7:0] CMD_STOP     = 8'h34;
  localparam logic [7:0] CMD_SIG      = 8'h49;
  localparam logic [7:0] CMD_RDBUF    = 8'h52;
  localparam logic [7:0] CMD_STATUS   = 8'h53;
  localparam logic [7:0] CMD_NONCE_RD = 8'h6E;
  localparam logic [7:0] CMD_WRBLK    = 8'h38;
  localparam logic [7:0] CMD_TARGET   = 8'h54;
  localparam logic [7:0] CMD_NONCE    = 8'h4E;
  localparam logic [7:0] CMD_TS       = 8'h57;
  localparam logic [7:0] CMD_CLK      = 8'h43;

  localparam logic [2:0] SEL_BLOCK  = 3'd0;
  localparam logic [2:0] SEL_TARGET = 3'd1;
  localparam logic [2:0] SEL_NONCE  = 3'd2;
  localparam logic [2:0] SEL_TS     = 3'd3;
  localparam logic [2:0] SEL_CLK    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2,
    ST_CLKARG  = 2'd3
  } state_e;

  function automatic logic is_simple_cmd(input logic [7:0] b);
    case (b)
      CMD_REBOOT, CMD_BREAK, CMD_START, CMD_STOP,
      CMD_SIG, CMD_RDBUF, CMD_STATUS, CMD_NONCE_RD: is_simple_cmd = 1'b1;
      default:                                      is_simple_cmd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/link_cmd_rx_word_packer.sv
// Little-endian byte-to-word packer with lane/word counters and a running
// XOR checksum; cleared at the start of every write transfer.
module link_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk_25,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_word_next,
  output logic [ADDR_W-1:0]       o_word_idx,
  output logic                    o_last_byte,
  output logic [7:0]              o_acc
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int BI_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [WORD_W-1:0] r_word;
  logic [BI_W-1:0]   r_byte_idx;
  logic [ADDR_W-1:0] r_word_idx;
  logic [7:0]        r_acc;
  logic [WORD_W-1:0] w_word_next;

  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_byte_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word_next = w_word_next;
  assign o_word_idx  = r_word_idx;
  assign o_last_byte = (r_byte_idx == BI_W'(WORD_BYTES - 1));
  assign o_acc       = r_acc;

  // A completed word is handed out via o_word_next, so the shift register restarts empty.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_acc      <= 8'h00;
    end else if (i_clr) begin
      r_word     <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_acc      <= 8'h00;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_byte;
      if (o_last_byte) begin
        r_word     <= '0;
        r_byte_idx <= '0;
        r_word_idx <= r_word_idx + ADDR_W'(1);
      end else begin
        r_word     <= w_word_next;
        r_byte_idx <= r_byte_idx + BI_W'(1);
      end
    end
  end

endmodule

// File: rtl/link_cmd_rx.sv
// Host-link command receiver: decodes single-byte commands, assembles write
// payloads into words, checks the trailing XOR and aborts stalled transfers.
module link_cmd_rx
  import link_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 5,
  parameter int BLK_WORDS   = 20,
  parameter int TGT_WORDS   = 8,
  parameter int NONCE_WORDS = 1,
  parameter int TS_WORDS    = 1,
  parameter int CSUM_EN     = 1,
  parameter int WDT_CYCLES  = 432
) (
  input  logic                    clk_25,
  input  logic                    rst_n,
  input  logic                    rx_byte_rsvd,
  input  logic [7:0]              rx_byte,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_code,
  output logic                    wr_busy,
  output logic [2:0]              wr_sel,
  output logic                    wr_word_valid,
  output logic [8*WORD_BYTES-1:0] wr_word,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    wr_done,
  output logic                    wr_err,
  output logic [1:0]              err_code,
  output logic                    go_reconfig,
  output logic [7:0]              clk_arg
);
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int WDT_W  = $clog2(WDT_CYCLES + 1);
  localparam int CNT_W  = ADDR_W + 1;

  state_e            r_state, w_state_nxt;
  logic [WDT_W-1:0]  r_wdt;
  logic [CNT_W-1:0]  r_words, w_words_nxt;
  logic              r_fin_pend, w_fin_pend_nxt;
  logic              r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0]        r_cmd_code, w_cmd_code_nxt;
  logic              r_busy, w_busy_nxt;
  logic [2:0]        r_sel, w_sel_nxt;
  logic              r_word_valid, w_word_valid_nxt;
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_err_code, w_err_code_nxt;
  logic              r_go, w_go_nxt;
  logic [7:0]        r_clk_arg, w_clk_arg_nxt;
  logic              w_pk_clr, w_pk_en, w_wdt_hit;
  logic [WORD_W-1:0] w_word_next;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_last_byte;
  logic [7:0]        w_acc;

  link_word_packer #(.WORD_BYTES(WORD_BYTES), .ADDR_W(ADDR_W)) u_packer (
    .clk_25      (clk_25),
    .rst_n       (rst_n),
    .i_clr       (w_pk_clr),
    .i_en        (w_pk_en),
    .i_byte      (rx_byte),
    .o_word_next (w_word_next),
    .o_word_idx  (w_word_idx),
    .o_last_byte (w_last_byte),
    .o_acc       (w_acc)
  );

  // An incoming byte in the terminal-count cycle takes priority over the abort.
  assign w_wdt_hit = (r_state != ST_IDLE) && !rx_byte_rsvd && (r_wdt == WDT_W'(WDT_CYCLES - 1));

  always_comb begin
    w_state_nxt      = r_state;
    w_words_nxt      = r_words;
    w_fin_pend_nxt   = 1'b0;
    w_cmd_valid_nxt  = 1'b0;
    w_cmd_code_nxt   = r_cmd_code;
    w_busy_nxt       = r_busy;
    w_sel_nxt        = r_sel;
    w_word_valid_nxt = 1'b0;
    w_word_nxt       = r_word;
    w_addr_nxt       = r_addr;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_err_code_nxt   = r_err_code;
    w_go_nxt         = 1'b0;
    w_clk_arg_nxt    = r_clk_arg;
    w_pk_clr         = 1'b0;
    w_pk_en          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_byte_rsvd) begin
          if (is_simple_cmd(rx_byte)) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_code_nxt  = rx_byte;
          end else begin
            w_pk_clr = 1'b1;
            case (rx_byte)
              CMD_WRBLK:  begin w_sel_nxt = SEL_BLOCK;  w_words_nxt = CNT_W'(BLK_WORDS);   end
              CMD_TARGET: begin w_sel_nxt = SEL_TARGET; w_words_nxt = CNT_W'(TGT_WORDS);   end
              CMD_NONCE:  begin w_sel_nxt = SEL_NONCE;  w_words_nxt = CNT_W'(NONCE_WORDS); end
              CMD_TS:     begin w_sel_nxt = SEL_TS;     w_words_nxt = CNT_W'(TS_WORDS);    end
              CMD_CLK:    begin w_sel_nxt = SEL_CLK;    end
              default:    begin end
            endcase
            if (rx_byte == CMD_CLK) begin
              w_busy_nxt  = 1'b1;
              w_state_nxt = ST_CLKARG;
            end else if (rx_byte == CMD_WRBLK || rx_byte == CMD_TARGET ||
                         rx_byte == CMD_NONCE || rx_byte == CMD_TS) begin
              w_busy_nxt  = 1'b1;
              w_state_nxt = ST_PAYLOAD;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        // Without a checksum, wr_done waits one cycle behind the final word.
        if (r_fin_pend) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (rx_byte_rsvd) begin
          w_pk_en = 1'b1;
          if (w_last_byte) begin
            w_word_valid_nxt = 1'b1;
            w_word_nxt       = w_word_next;
            w_addr_nxt       = w_word_idx;
            if ({1'b0, w_word_idx} == r_words - CNT_W'(1)) begin
              if (CSUM_EN != 0) begin
                w_state_nxt = ST_CSUM;
              end else begin
                w_fin_pend_nxt = 1'b1;
              end
            end else begin
              w_state_nxt = ST_PAYLOAD;
            end
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_wdt_hit) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (rx_byte_rsvd) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          if (rx_byte == w_acc) begin
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_CSUM;
          end
        end else if (w_wdt_hit) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_CSUM;
        end
      end
      ST_CLKARG: begin
        if (rx_byte_rsvd) begin
          w_go_nxt      = 1'b1;
          w_clk_arg_nxt = rx_byte;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (w_wdt_hit) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLKARG;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wdt        <= '0;
      r_words      <= '0;
      r_fin_pend   <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= 8'h00;
      r_busy       <= 1'b0;
      r_sel        <= 3'd0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_addr       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
      r_go         <= 1'b0;
      r_clk_arg    <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_wdt        <= (r_state == ST_IDLE || rx_byte_rsvd) ? '0 : r_wdt + WDT_W'(1);
      r_words      <= w_words_nxt;
      r_fin_pend   <= w_fin_pend_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_code   <= w_cmd_code_nxt;
      r_busy       <= w_busy_nxt;
      r_sel        <= w_sel_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_word       <= w_word_nxt;
      r_addr       <= w_addr_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
      r_go         <= w_go_nxt;
      r_clk_arg    <= w_clk_arg_nxt;
    end
  end

  assign cmd_valid     = r_cmd_valid;
  assign cmd_code      = r_cmd_code;
  assign wr_busy       = r_busy;
  assign wr_sel        = r_sel;
  assign wr_word_valid = r_word_valid;
  assign wr_word       = r_word;
  assign wr_addr       = r_addr;
  assign wr_done       = r_done;
  assign wr_err        = r_err;
  assign err_code      = r_err_code;
  assign go_reconfig   = r_go;
  assign clk_arg       = r_clk_arg;

endmodule

// File: tb/tb_link_cmd_rx.sv
// Scoreboard bench for link_cmd_rx: directed byte streams push expected
// events; a negedge monitor pops and compares whenever the DUT strobes.
module tb_link_cmd_rx;
  logic        clk_25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_byte_rsvd = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_valid, wr_busy, wr_word_valid, wr_done, wr_err, go_reconfig;
  logic [7:0]  cmd_code, clk_arg;
  logic [2:0]  wr_sel;
  logic [31:0] wr_word;
  logic [4:0]  wr_addr;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [2:0] sel; logic [4:0] addr; logic [31:0] word; } wexp_t;
  typedef struct { logic is_err; logic [1:0] code; } eexp_t;
  logic [7:0] q_cmd[$];
  wexp_t      q_word[$];
  eexp_t      q_end[$];
  logic [7:0] q_go[$];

  link_cmd_rx dut (
    .clk_25(clk_25), .rst_n(rst_n), .rx_byte_rsvd(rx_byte_rsvd), .rx_byte(rx_byte),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .wr_busy(wr_busy), .wr_sel(wr_sel),
    .wr_word_valid(wr_word_valid), .wr_word(wr_word), .wr_addr(wr_addr),
    .wr_done(wr_done), .wr_err(wr_err), .err_code(err_code),
    .go_reconfig(go_reconfig), .clk_arg(clk_arg)
  );

  always #20 clk_25 = ~clk_25;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected strobe, got 1 expected 0", name);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_25);
    rx_byte_rsvd = 1'b1;
    rx_byte      = b;
    @(negedge clk_25);
    rx_byte_rsvd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic push_word(input logic [2:0] s, input logic [4:0] a, input logic [31:0] w);
    wexp_t e;
    e.sel = s; e.addr = a; e.word = w;
    q_word.push_back(e);
  endtask

  task automatic push_end(input logic is_err, input logic [1:0] code);
    eexp_t e;
    e.is_err = is_err; e.code = code;
    q_end.push_back(e);
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue.
  always @(negedge clk_25) begin
    if (rst_n) begin
      if (cmd_valid) begin
        if (q_cmd.size() == 0) unexpected("cmd_valid");
        else chk("cmd_code", cmd_code, q_cmd.pop_front());
      end
      if (wr_word_valid) begin
        if (q_word.size() == 0) unexpected("wr_word_valid");
        else begin
          wexp_t e;
          e = q_word.pop_front();
          chk("wr_word", wr_word, e.word);
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_sel", wr_sel, e.sel);
          chk("wr_busy_during_word", wr_busy, 1'b1);
        end
      end
      if (wr_done || wr_err) begin
        if (q_end.size() == 0) unexpected(wr_done ? "wr_done" : "wr_err");
        else begin
          eexp_t e;
          e = q_end.pop_front();
          chk("end_is_err", {wr_done, wr_err}, e.is_err ? 2'b01 : 2'b10);
          if (e.is_err) chk("err_code", err_code, e.code);
          chk("wr_busy_at_end", wr_busy, 1'b0);
          chk("words_before_end", q_word.size(), 0);
        end
      end
      if (go_reconfig) begin
        if (q_go.size() == 0) unexpected("go_reconfig");
        else chk("clk_arg", clk_arg, q_go.pop_front());
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {cmd_valid, cmd_code, wr_busy, wr_sel, wr_word_valid, wr_word,
                         wr_addr, wr_done, wr_err, err_code, go_reconfig, clk_arg}, 64'd0);
  endtask

  initial begin
    logic [7:0] x;
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Simple command, then an unknown byte that must produce nothing.
    q_cmd.push_back(8'h53);
    send(8'h53);
    idle(3);
    send(8'hFF);
    idle(4);
    chk("cmd_queue_drained", q_cmd.size(), 0);

    // Nonce write with correct checksum.
    push_word(3'd2, 5'd0, 32'h12345678);
    push_end(1'b0, 2'd0);
    send(8'h4E);
    chk("busy_nonce_start", wr_busy, 1'b1);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("busy_nonce_mid", wr_busy, 1'b1);
    send(8'h08);
    idle(4);
    chk("busy_nonce_after", wr_busy, 1'b0);

    // Block write: 80 bytes 0x00..0x4F.
    x = 8'h00;
    for (int w = 0; w < 20; w++)
      push_word(3'd0, w[4:0], {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    push_end(1'b0, 2'd0);
    send(8'h38);
    for (int i = 0; i < 80; i++) begin
      send(8'(i));
      x = x ^ 8'(i);
    end
    send(x);
    idle(4);

    // Target write with a wrong checksum.
    x = 8'h00;
    for (int w = 0; w < 8; w++)
      push_word(3'd1, w[4:0], {8'(8'hA3 + 4*w), 8'(8'hA2 + 4*w), 8'(8'hA1 + 4*w), 8'(8'hA0 + 4*w)});
    push_end(1'b1, 2'd2);
    send(8'h54);
    for (int i = 0; i < 32; i++) begin
      send(8'(8'hA0 + i));
      x = x ^ 8'(8'hA0 + i);
    end
    send(x ^ 8'h5A);
    idle(4);

    // Timestamp stalls after 2 bytes: timeout near 432 idle cycles.
    push_end(1'b1, 2'd1);
    send(8'h57);
    send(8'h11);
    send(8'h22);
    idle(424);
    chk("wdt_not_early", q_end.size(), 1);
    idle(16);
    chk("wdt_fired", q_end.size(), 0);
    q_cmd.push_back(8'h53);
    send(8'h53);
    idle(3);

    // Clock argument.
    q_go.push_back(8'h05);
    send(8'h43);
    send(8'h05);
    idle(3);
    chk("go_queue_drained", q_go.size(), 0);

    // Reset mid block-write after 10 bytes: two words already out, then silence.
    push_word(3'd0, 5'd0, 32'h03020100);
    push_word(3'd0, 5'd1, 32'h07060504);
    send(8'h38);
    for (int i = 0; i < 10; i++) send(8'(i));
    @(negedge clk_25);
    rst_n = 1'b0;
    idle(2);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    idle(2);
    push_word(3'd2, 5'd0, 32'hDDCCBBAA);
    push_end(1'b0, 2'd0);
    send(8'h4E);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
    idle(5);

    chk("final_cmd_q", q_cmd.size(), 0);
    chk("final_word_q", q_word.size(), 0);
    chk("final_end_q", q_end.size(), 0);
    chk("final_go_q", q_go.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/link_cmd_rx.md
Name: link_cmd_rx

Overview:
- Parametrised successor to the host-link byte receiver. Sits between the UART byte receiver and the system RAM / control logic on clk_25.
- Decodes single-byte commands into one-cycle strobes.
- For write commands, collects a per-command-length payload and packs little-endian bytes into WORD_BYTES-wide words with addresses.
- Optionally verifies a trailing XOR checksum. A programmable inter-byte watchdog aborts stalled transfers with an error code.

Parameters:
- WORD_BYTES, 4: bytes per assembled word (1..8); WORD_W = 8*WORD_BYTES.
- ADDR_W, 5: word-address width; must satisfy 2^ADDR_W >= max payload words.
- BLK_WORDS, 20: payload words for wr_block (0x38).
- TGT_WORDS, 8: payload words for set_target (0x54).
- NONCE_WORDS, 1: payload words for set_nonce (0x4E).
- TS_WORDS, 1: payload words for set_timestamp (0x57).
- CSUM_EN, 1: 1 = payload is followed by one XOR checksum byte.
- WDT_CYCLES, 432: max idle clk_25 cycles between payload bytes before abort.

Ports:
- clk_25  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_byte_rsvd  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- cmd_valid  out  1  one-cycle strobe, single-byte command decoded
- cmd_code  out  8  command byte, held until next cmd_valid
- wr_busy  out  1  high while a write transfer is in progress
- wr_sel  out  3  target: 0 block, 1 target, 2 nonce, 3 timestamp, 4 clk
- wr_word_valid  out  1  one-cycle strobe, wr_word/wr_addr valid
- wr_word  out  WORD_W  assembled word, first byte in [7:0]
- wr_addr  out  ADDR_W  word index within payload, from 0
- wr_done  out  1  one-cycle strobe, transfer complete and checksum good
- wr_err  out  1  one-cycle strobe, transfer aborted
- err_code  out  2  1 timeout, 2 checksum, held until next wr_err
- go_reconfig  out  1  one-cycle strobe with the set_clk argument byte
- clk_arg  out  8  set_clk argument, held

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0. Word shift register, byte/word counters, checksum accumulator and watchdog are cleared.
- Reset mid-transfer: the transfer is abandoned. No wr_done or wr_err is emitted.
- States: IDLE, PAYLOAD, CSUM, CLKARG.
- IDLE, on rx_byte_rsvd:
  - 0x30/31/32/34/49/52/53/6E: cmd_valid=1 and cmd_code=byte on the next cycle (latency 1). Stay in IDLE.
  - 0x38/54/4E/57: load wr_sel, word count = the matching *_WORDS, clear the counters, accumulator and wdt. Set wr_busy=1. Go to PAYLOAD.
  - 0x43: wr_sel=4, wr_busy=1, go to CLKARG.
  - Any other byte: ignored, no output.
- PAYLOAD:
  - Each byte shifts into lane byte_idx of the word and is XORed into the accumulator; wdt cleared.
  - On the byte completing a word: wr_word_valid=1 next cycle with the full word and wr_addr = word_idx. word_idx increments and byte_idx wraps to 0.
  - After the last word: go to CSUM if CSUM_EN, else pulse wr_done and go to IDLE.
- CSUM: next byte compared with the accumulator.
  - Equal: wr_done pulse.
  - Not equal: wr_err with err_code=2.
  - Either case: go to IDLE.
  - Words already emitted are not retracted; the sink discards them on wr_err.
- CLKARG: next byte -> clk_arg, go_reconfig pulse, go to IDLE. There is no checksum on this byte.
- Watchdog:
  - In PAYLOAD, CSUM and CLKARG, wdt counts every cycle without rx_byte_rsvd.
  - When wdt reaches WDT_CYCLES: wr_err with err_code=1, go to IDLE, partial word dropped.
  - A byte arriving in the same cycle as the wdt terminal count wins: the byte is accepted and wdt is cleared.
- wr_busy deasserts on the same cycle as the wr_done or wr_err pulse.
- Command bytes received during PAYLOAD or CSUM are treated as data, never decoded.
- wr_done, wr_err and wr_word_valid are registered. The last wr_word_valid precedes wr_done by at least one cycle.

Decomposition:
- Package link_pkg holds:
  - command byte constants: CMD_REBOOT, CMD_BREAK, CMD_START, CMD_STOP, CMD_SIG, CMD_RDBUF, CMD_STATUS, CMD_NONCE_RD, CMD_WRBLK, CMD_TARGET, CMD_NONCE, CMD_TS, CMD_CLK;
  - wr_sel encodings;
  - err_code encodings;
  - state encodings.
- One natural sub-module, link_word_packer: byte shift-in, lane counter, word/address counter and XOR accumulator, with clear/enable inputs. The FSM and watchdog stay in link_cmd_rx.

Test Plan:
- Byte 0x53 in IDLE -> cmd_valid one cycle later with cmd_code=0x53; no wr_* activity. Then 0xFF -> no output at all.
- 0x4E, then 78 56 34 12, then checksum 0x08 -> one wr_word_valid with wr_word=0x12345678, wr_addr=0, wr_sel=2, then wr_done; wr_busy high throughout the transfer.
- 0x38 plus 80 bytes 0x00..0x4F plus correct XOR -> 20 wr_word_valid pulses, addr 0..19, word 0 = 0x03020100, then wr_done.
- 0x54 plus 32 bytes plus wrong checksum -> 8 words emitted, then wr_err with err_code=2; no wr_done.
- 0x57 plus 2 bytes, then silence for 432 cycles -> wr_err with err_code=1, no wr_word_valid. A following 0x53 decodes normally.
- 0x43 then 0x05 -> go_reconfig pulse with clk_arg=0x05. Separately: rst_n low after 10 bytes of wr_block -> all outputs 0 and no wr_err; a fresh 0x4E transfer then completes.
